// File: rtl/ysyx_25040101_lsu_ctrl_pkg.sv
// Shared types and constants for the load/store sequencer: FSM states, op decode,
// mem_en_i bit positions and err_o bit positions.
package ysyx_25040101_lsu_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MASK_W   = 4;
  localparam int unsigned MEM_EN_W = 7;
  localparam int unsigned ERR_W    = 2;

  localparam int unsigned MEM_RD1B  = 0;
  localparam int unsigned MEM_RD2B  = 1;
  localparam int unsigned MEM_RD2BS = 2;
  localparam int unsigned MEM_RD4B  = 3;
  localparam int unsigned MEM_WR1B  = 4;
  localparam int unsigned MEM_WR2B  = 5;
  localparam int unsigned MEM_WR4B  = 6;

  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_BUS      = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_RD1B  = 3'd1,
    OP_RD2B  = 3'd2,
    OP_RD2BS = 3'd3,
    OP_RD4B  = 3'd4,
    OP_WR1B  = 3'd5,
    OP_WR2B  = 3'd6,
    OP_WR4B  = 3'd7
  } op_e;

  // Multiple request bits resolve with reads first, widest first.
  function automatic op_e decode_op(input logic [MEM_EN_W-1:0] en);
    op_e op;
    op = OP_NONE;
    if      (en[MEM_RD4B])  op = OP_RD4B;
    else if (en[MEM_RD2BS]) op = OP_RD2BS;
    else if (en[MEM_RD2B])  op = OP_RD2B;
    else if (en[MEM_RD1B])  op = OP_RD1B;
    else if (en[MEM_WR4B])  op = OP_WR4B;
    else if (en[MEM_WR2B])  op = OP_WR2B;
    else if (en[MEM_WR1B])  op = OP_WR1B;
    return op;
  endfunction

  function automatic logic op_is_write(input op_e op);
    return (op == OP_WR1B) || (op == OP_WR2B) || (op == OP_WR4B);
  endfunction

  function automatic logic op_misaligned(input op_e op, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_RD4B, OP_WR4B:           mis = (lo != 2'b00);
      OP_RD2B, OP_RD2BS, OP_WR2B: mis = lo[0];
      default:                    mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_25040101_lsu_lane.sv
// Byte-lane logic: store strobes and replicated store data, plus load extraction
// and zero/sign extension from the addressed lane.
module ysyx_25040101_lsu_lane
  import ysyx_25040101_lsu_ctrl_pkg::*;
(
  input  op_e               op_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [MASK_W-1:0] wmask_c_o,
  output logic [XLEN-1:0]   wdata_c_o,
  output logic [XLEN-1:0]   rdata_c_o
);

  logic [15:0] lane_rd;

  assign lane_rd = 16'(rdata_i >> {addr_lo_i, 3'b000});

  always_comb begin
    wmask_c_o = '0;
    wdata_c_o = '0;
    rdata_c_o = '0;
    case (op_i)
      OP_WR1B: begin
        wmask_c_o = MASK_W'(4'b0001 << addr_lo_i);
        wdata_c_o = {4{wdata_i[7:0]}};
      end
      OP_WR2B: begin
        wmask_c_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_c_o = {2{wdata_i[15:0]}};
      end
      OP_WR4B: begin
        wmask_c_o = 4'b1111;
        wdata_c_o = wdata_i;
      end
      OP_RD1B:  rdata_c_o = {24'h0, lane_rd[7:0]};
      OP_RD2B:  rdata_c_o = {16'h0, lane_rd};
      OP_RD2BS: rdata_c_o = {{16{lane_rd[15]}}, lane_rd};
      OP_RD4B:  rdata_c_o = rdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25040101_lsu_ctrl.sv
// Load/store sequencer: latches one memory op, issues a valid/ready bus request,
// waits for the response (bounded by a timeout) and reports result/error to the core.
module ysyx_25040101_lsu_ctrl
  import ysyx_25040101_lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [MEM_EN_W-1:0] mem_en_i,
  input  logic [XLEN-1:0]     addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic                req_we_o,
  output logic [XLEN-1:0]     req_addr_o,
  output logic [XLEN-1:0]     req_wdata_o,
  output logic [MASK_W-1:0]   req_wmask_o,
  input  logic                rsp_valid_i,
  input  logic [XLEN-1:0]     rsp_rdata_i,
  input  logic                rsp_err_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [XLEN-1:0]     rdata_o,
  output logic [ERR_W-1:0]    err_o
);

  // One spare count so an acceptance on the timeout cycle cannot wrap the counter.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [1:0]          lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                valid_q, valid_d;
  logic                we_q, we_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic [ERR_W-1:0]    err_q, err_d;

  op_e                 op_in;
  op_e                 lane_op;
  logic [1:0]          lane_lo;
  logic [MASK_W-1:0]   lane_wmask;
  logic [XLEN-1:0]     lane_wdata;
  logic [XLEN-1:0]     lane_rdata;
  logic                timeout_hit;

  assign op_in       = decode_op(mem_en_i);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= CNT_W'(TIMEOUT_CYCLES));

  // Lane logic sees the incoming op while idle and the latched op afterwards.
  assign lane_op = (state_q == ST_IDLE) ? op_in : op_q;
  assign lane_lo = (state_q == ST_IDLE) ? addr_i[1:0] : lo_q;

  ysyx_25040101_lsu_lane u_lane (
    .op_i      (lane_op),
    .addr_lo_i (lane_lo),
    .wdata_i   (wdata_i),
    .rdata_i   (rsp_rdata_i),
    .wmask_c_o (lane_wmask),
    .wdata_c_o (lane_wdata),
    .rdata_c_o (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      lo_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = op_in;
          lo_d    = addr_i[1:0];
          cnt_d   = '0;
          we_d    = op_is_write(op_in);
          addr_d  = {addr_i[XLEN-1:2], 2'b00};
          wdata_d = lane_wdata;
          wmask_d = lane_wmask;
          rdata_d = '0;
          err_d   = '0;
          if (op_in == OP_NONE) begin
            state_d = ST_FIN;
          end else if (op_misaligned(op_in, addr_i[1:0])) begin
            state_d             = ST_FIN;
            err_d[ERR_MISALIGN] = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        if (valid_q && req_ready_i) begin
          state_d = ST_RSP;
        end else if (timeout_hit) begin
          state_d        = ST_FIN;
          err_d[ERR_BUS] = 1'b1;
        end
      end
      ST_RSP: begin
        cnt_d = cnt_inc;
        if (rsp_valid_i) begin
          state_d        = ST_FIN;
          err_d[ERR_BUS] = rsp_err_i;
          rdata_d        = rsp_err_i ? '0 : lane_rdata;
        end else if (timeout_hit) begin
          state_d        = ST_FIN;
          err_d[ERR_BUS] = 1'b1;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_REQ);
    busy_d  = (state_d == ST_REQ) || (state_d == ST_RSP);
    done_d  = (state_d == ST_FIN);
  end

  assign req_valid_o = valid_q;
  assign req_we_o    = we_q;
  assign req_addr_o  = addr_q;
  assign req_wdata_o = wdata_q;
  assign req_wmask_o = wmask_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ysyx_25040101_lsu_ctrl.sv
// Directed bench for the load/store sequencer: loads, stores, misalignment,
// stall, timeout, bus error, busy-start rejection and mid-op reset.
module tb_ysyx_25040101_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [6:0]  mem_en_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic [3:0]  req_wmask_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_rdata_i;
  logic        rsp_err_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic [1:0]  err_o;

  int n_chk;
  int n_fail;

  localparam logic [6:0] EN_LBU = 7'b0000001;
  localparam logic [6:0] EN_LHU = 7'b0000010;
  localparam logic [6:0] EN_LH  = 7'b0000100;
  localparam logic [6:0] EN_LW  = 7'b0001000;
  localparam logic [6:0] EN_SB  = 7'b0010000;
  localparam logic [6:0] EN_SH  = 7'b0100000;
  localparam logic [6:0] EN_SW  = 7'b1000000;

  ysyx_25040101_lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .mem_en_i    (mem_en_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .req_we_o    (req_we_o),
    .req_addr_o  (req_addr_o),
    .req_wdata_o (req_wdata_o),
    .req_wmask_o (req_wmask_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_rdata_i (rsp_rdata_i),
    .rsp_err_i   (rsp_err_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [6:0] en, input logic [31:0] a, input logic [31:0] wd);
    mem_en_i = en;
    addr_i   = a;
    wdata_i  = wd;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    mem_en_i = '0;
  endtask

  // Full transaction with an always-ready bus and a response one idle cycle after acceptance.
  task automatic bus_op(input string tag, input logic [6:0] en, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic rerr,
                        input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata, input logic exp_we,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err);
    req_ready_i = 1'b1;
    start_op(en, a, wd);
    check_eq({tag, ".valid"}, 32'(req_valid_o), 32'd1);
    check_eq({tag, ".busy"},  32'(busy_o),      32'd1);
    check_eq({tag, ".addr"},  req_addr_o,       exp_addr);
    check_eq({tag, ".wmask"}, 32'(req_wmask_o), 32'(exp_mask));
    check_eq({tag, ".wdata"}, req_wdata_o,      exp_wdata);
    check_eq({tag, ".we"},    32'(req_we_o),    32'(exp_we));
    tick();
    req_ready_i = 1'b0;
    check_eq({tag, ".valid_drop"}, 32'(req_valid_o), 32'd0);
    check_eq({tag, ".done_early"}, 32'(done_o),      32'd0);
    tick();
    rsp_valid_i = 1'b1;
    rsp_rdata_i = rd;
    rsp_err_i   = rerr;
    tick();
    rsp_valid_i = 1'b0;
    rsp_err_i   = 1'b0;
    check_eq({tag, ".done"},  32'(done_o), 32'd1);
    check_eq({tag, ".busy0"}, 32'(busy_o), 32'd0);
    check_eq({tag, ".rdata"}, rdata_o,     exp_rdata);
    check_eq({tag, ".err"},   32'(err_o),  32'(exp_err));
    tick();
    check_eq({tag, ".pulse"}, 32'(done_o), 32'd0);
    check_eq({tag, ".hold"},  rdata_o,     exp_rdata);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    start_i     = 1'b0;
    mem_en_i    = '0;
    addr_i      = '0;
    wdata_i     = '0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_rdata_i = '0;
    rsp_err_i   = 1'b0;
    tick();
    tick();
    check_eq("rst.valid", 32'(req_valid_o), 32'd0);
    check_eq("rst.busy",  32'(busy_o),      32'd0);
    check_eq("rst.done",  32'(done_o),      32'd0);
    check_eq("rst.addr",  req_addr_o,       32'd0);
    check_eq("rst.rdata", rdata_o,          32'd0);
    check_eq("rst.err",   32'(err_o),       32'd0);
    rst = 1'b0;
    tick();

    bus_op("lw",   EN_LW,  32'h8000_0104, 32'h0, 32'hDEAD_BEEF, 1'b0,
           32'h8000_0104, 4'b0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 2'b00);
    bus_op("lh",   EN_LH,  32'h8000_0002, 32'h0, 32'h8001_7F00, 1'b0,
           32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'hFFFF_8001, 2'b00);
    bus_op("lhu",  EN_LHU, 32'h8000_0002, 32'h0, 32'h8001_7F00, 1'b0,
           32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h0000_8001, 2'b00);
    bus_op("lbu",  EN_LBU, 32'h8000_0003, 32'h0, 32'h8001_7F00, 1'b0,
           32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h0000_0080, 2'b00);
    bus_op("sb",   EN_SB,  32'h8000_0001, 32'h0000_00AB, 32'h1234_5678, 1'b0,
           32'h8000_0000, 4'b0010, 32'hABAB_ABAB, 1'b1, 32'h0, 2'b00);
    bus_op("sh",   EN_SH,  32'h8000_0002, 32'h0000_BEEF, 32'h0, 1'b0,
           32'h8000_0000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0, 2'b00);
    bus_op("sw",   EN_SW,  32'h8000_0008, 32'h0123_4567, 32'h0, 1'b0,
           32'h8000_0008, 4'b1111, 32'h0123_4567, 1'b1, 32'h0, 2'b00);
    bus_op("prio", 7'b1001001, 32'h8000_0004, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b0,
           32'h8000_0004, 4'b0000, 32'h0, 1'b0, 32'hCAFE_F00D, 2'b00);
    bus_op("lh7f", EN_LH,  32'h8000_0000, 32'h0, 32'hFFFF_7FFF, 1'b0,
           32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h0000_7FFF, 2'b00);
    bus_op("berr", EN_LW,  32'h8000_0010, 32'h0, 32'h5555_5555, 1'b1,
           32'h8000_0010, 4'b0000, 32'h0, 1'b0, 32'h0, 2'b10);

    // Leave a nonzero result so the misaligned start must clear it.
    bus_op("lw2",  EN_LW,  32'h8000_0020, 32'h0, 32'h0BAD_F00D, 1'b0,
           32'h8000_0020, 4'b0000, 32'h0, 1'b0, 32'h0BAD_F00D, 2'b00);
    req_ready_i = 1'b1;
    start_op(EN_LW, 32'h8000_0002, 32'h0);
    check_eq("mis.valid", 32'(req_valid_o), 32'd0);
    check_eq("mis.done",  32'(done_o),      32'd1);
    check_eq("mis.busy",  32'(busy_o),      32'd0);
    check_eq("mis.err",   32'(err_o),       32'd1);
    check_eq("mis.rdata", rdata_o,          32'd0);
    tick();
    check_eq("mis.pulse", 32'(done_o),      32'd0);
    check_eq("mis.hold",  32'(err_o),       32'd1);
    start_op(EN_SH, 32'h8000_0003, 32'h0);
    check_eq("mish.err",  32'(err_o),       32'd1);
    check_eq("mish.valid", 32'(req_valid_o), 32'd0);
    tick();
    start_op(7'b0000000, 32'h8000_0000, 32'h0);
    check_eq("noop.done", 32'(done_o),      32'd1);
    check_eq("noop.err",  32'(err_o),       32'd0);
    check_eq("noop.valid", 32'(req_valid_o), 32'd0);
    tick();

    // Stall with a second start attempted while busy.
    req_ready_i = 1'b0;
    start_op(EN_LW, 32'h8000_0040, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall.valid", 32'(req_valid_o), 32'd1);
      check_eq("stall.addr",  req_addr_o,       32'h8000_0040);
      check_eq("stall.we",    32'(req_we_o),    32'd0);
      check_eq("stall.wmask", 32'(req_wmask_o), 32'd0);
      if (i == 2) begin
        mem_en_i = EN_SW;
        addr_i   = 32'h8000_0080;
        wdata_i  = 32'hFFFF_FFFF;
        start_i  = 1'b1;
      end
      tick();
      start_i  = 1'b0;
      mem_en_i = '0;
    end
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    check_eq("stall.acc", 32'(req_valid_o), 32'd0);
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'h1122_3344;
    tick();
    rsp_valid_i = 1'b0;
    check_eq("stall.done",  32'(done_o), 32'd1);
    check_eq("stall.rdata", rdata_o,     32'h1122_3344);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("busy_start.no2nd_valid", 32'(req_valid_o), 32'd0);
      check_eq("busy_start.no2nd_done",  32'(done_o),      32'd0);
    end

    // Timeout: ready never asserted, limit is 8 cycles.
    start_op(EN_LW, 32'h8000_0050, 32'h0);
    for (int i = 1; i < 8; i++) begin
      check_eq("tmo.wait_valid", 32'(req_valid_o), 32'd1);
      check_eq("tmo.wait_done",  32'(done_o),      32'd0);
      tick();
    end
    check_eq("tmo.last_valid", 32'(req_valid_o), 32'd1);
    tick();
    check_eq("tmo.done",  32'(done_o),      32'd1);
    check_eq("tmo.valid", 32'(req_valid_o), 32'd0);
    check_eq("tmo.busy",  32'(busy_o),      32'd0);
    check_eq("tmo.err",   32'(err_o),       32'd2);
    tick();
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'h7777_7777;
    tick();
    rsp_valid_i = 1'b0;
    check_eq("late.done",  32'(done_o), 32'd0);
    check_eq("late.busy",  32'(busy_o), 32'd0);
    check_eq("late.rdata", rdata_o,     32'd0);

    // Reset while waiting for the response.
    req_ready_i = 1'b1;
    start_op(EN_LW, 32'h8000_0060, 32'h0);
    tick();
    req_ready_i = 1'b0;
    check_eq("rsp.busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("mrst.busy",  32'(busy_o),      32'd0);
    check_eq("mrst.done",  32'(done_o),      32'd0);
    check_eq("mrst.addr",  req_addr_o,       32'd0);
    check_eq("mrst.valid", 32'(req_valid_o), 32'd0);
    rst = 1'b0;
    rsp_valid_i = 1'b1;
    tick();
    rsp_valid_i = 1'b0;
    check_eq("mrst.nodone", 32'(done_o), 32'd0);
    tick();
    check_eq("mrst.nodone2", 32'(done_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
